// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: walks the sprite attribute table once per scanline,
// picks the entries that cover the requested line and feeds each one to the
// sprite drawer as a single 16-pixel row via its start/done handshake.
module sprite_line_scheduler #(
  parameter  int NUM_SPRITES  = 64,
  parameter  int MAX_PER_LINE = 16,
  localparam int IDX_W        = $clog2(NUM_SPRITES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             line_start,
  input  logic [9:0]       line_y,
  output logic [IDX_W-1:0] attr_addr,
  input  logic [31:0]      attr_q,
  output logic             draw_start,
  output logic [9:0]       draw_col,
  output logic             draw_flip,
  output logic [7:0]       draw_frame,
  output logic [3:0]       draw_row,
  input  logic             draw_done,
  output logic             busy,
  output logic             line_done,
  output logic [4:0]       hit_count,
  output logic             overflow,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);
  localparam logic [4:0]       MAX_HC   = 5'(MAX_PER_LINE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EVAL,
    S_START,
    S_ACK,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [IDX_W-1:0] idx;
  logic [9:0]       y_q;
  logic [9:0]       diff;
  logic             hit;
  logic             take_hit;
  logic             last;
  logic             attr_unused;

  // Reserved attribute bits carry nothing for this block.
  assign attr_unused = ^attr_q[1:0];

  // Modular distance from the sprite's top row; wraps cleanly past line 1023.
  assign diff     = y_q - attr_q[19:10];
  assign hit      = attr_q[31] && (diff[9:4] == 6'd0);
  assign take_hit = hit && (hit_count < MAX_HC);
  assign last     = (idx == LAST_IDX);

  assign attr_addr = idx;
  assign busy      = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state and handshake strobes; a new line_start overrides everything.
  always_comb begin
    state_n    = state;
    draw_start = 1'b0;
    line_done  = 1'b0;
    overrun    = 1'b0;
    case (state)
      S_IDLE:   state_n = S_IDLE;
      S_FETCH:  state_n = S_EVAL;
      S_EVAL: begin
        if (take_hit)  state_n = S_START;
        else if (last) state_n = S_FINISH;
        else           state_n = S_FETCH;
      end
      S_START: begin
        draw_start = 1'b1;
        state_n    = S_ACK;
      end
      // The drawer only drops done one cycle after start, so done is stale here.
      S_ACK:    state_n = S_WAIT;
      S_WAIT: begin
        if (draw_done) state_n = last ? S_FINISH : S_FETCH;
      end
      S_FINISH: begin
        line_done = 1'b1;
        state_n   = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
    if (line_start) begin
      state_n   = S_FETCH;
      overrun   = (state != S_IDLE);
      line_done = 1'b0;
    end
  end

  // Target line is captured on every scan start.
  always_ff @(posedge clk) begin
    if (line_start) y_q <= line_y;
  end

  // Scan index, per-line counters and the drawer parameter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      hit_count  <= 5'd0;
      overflow   <= 1'b0;
      draw_col   <= 10'd0;
      draw_flip  <= 1'b0;
      draw_frame <= 8'd0;
      draw_row   <= 4'd0;
    end else if (line_start) begin
      idx       <= '0;
      hit_count <= 5'd0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_EVAL: begin
          if (take_hit) begin
            draw_col   <= attr_q[29:20];
            draw_flip  <= attr_q[30];
            draw_frame <= attr_q[9:2];
            draw_row   <= diff[3:0];
          end else begin
            if (hit)   overflow <= 1'b1;
            if (!last) idx      <= idx + IDX_W'(1);
          end
        end
        S_START: hit_count <= hit_count + 5'd1;
        S_WAIT: begin
          if (draw_done && !last) idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for sprite_line_scheduler with a SAT memory model and a
// drawer model whose busy time is LEN cycles after each start.
module tb_sprite_line_scheduler;

  localparam int LEN = 17;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        line_start = 1'b0;
  logic [9:0]  line_y = 10'd0;
  logic [5:0]  attr_addr;
  logic [31:0] attr_q;
  logic        draw_start;
  logic [9:0]  draw_col;
  logic        draw_flip;
  logic [7:0]  draw_frame;
  logic [3:0]  draw_row;
  logic        draw_done;
  logic        busy;
  logic        line_done;
  logic [4:0]  hit_count;
  logic        overflow;
  logic        overrun;

  logic [31:0] sat [64];
  int          dcnt = 0;
  logic        slow = 1'b0;

  int checks = 0;
  int failures = 0;

  // Results of the most recent run_scan.
  int          n_starts;
  int          stab_err;
  logic        ov0;
  logic        ld0;
  logic        busy1;
  int          st_k     [32];
  logic [9:0]  st_col   [32];
  logic        st_flip  [32];
  logic [7:0]  st_frame [32];
  logic [3:0]  st_row   [32];

  sprite_line_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .line_start (line_start),
    .line_y     (line_y),
    .attr_addr  (attr_addr),
    .attr_q     (attr_q),
    .draw_start (draw_start),
    .draw_col   (draw_col),
    .draw_flip  (draw_flip),
    .draw_frame (draw_frame),
    .draw_row   (draw_row),
    .draw_done  (draw_done),
    .busy       (busy),
    .line_done  (line_done),
    .hit_count  (hit_count),
    .overflow   (overflow),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // SAT: registered read, data valid the cycle after the address.
  always_ff @(posedge clk) attr_q <= sat[attr_addr];

  // Drawer: busy for LEN cycles after start; slow variant keeps done high one extra cycle.
  always_ff @(posedge clk) begin
    if (reset)           dcnt <= 0;
    else if (draw_start) dcnt <= LEN;
    else if (dcnt > 0)   dcnt <= dcnt - 1;
  end
  assign draw_done = (dcnt == 0) || (slow && dcnt == LEN);

  function automatic logic [31:0] ent(input logic en, input logic fl, input logic [9:0] x,
                                      input logic [9:0] y, input logic [7:0] fr);
    return {en, fl, x, y, fr, 2'b00};
  endfunction

  task automatic clear_sat();
    for (int i = 0; i < 64; i++) sat[i] = 32'd0;
  endtask

  // Pulses line_start (cycle 0) and follows the scan until line_done or budget.
  task automatic run_scan(input logic [9:0] y, input int budget, output int done_k);
    logic [9:0] c_col;
    logic       c_flip;
    logic [7:0] c_frame;
    logic [3:0] c_row;
    logic       hold;
    int         cs;
    n_starts = 0;
    stab_err = 0;
    hold     = 1'b0;
    cs       = 0;
    done_k   = -1;
    c_col = '0; c_flip = 1'b0; c_frame = '0; c_row = '0;
    @(posedge clk); #1;
    line_start = 1'b1;
    line_y     = y;
    @(negedge clk);
    ov0 = overrun;
    ld0 = line_done;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = busy;
      if (hold) begin
        if ({draw_col, draw_flip, draw_frame, draw_row} !== {c_col, c_flip, c_frame, c_row})
          stab_err++;
        cs++;
        if (draw_done && cs >= 2) hold = 1'b0;
      end
      if (draw_start) begin
        if (n_starts < 32) begin
          st_k[n_starts]     = k;
          st_col[n_starts]   = draw_col;
          st_flip[n_starts]  = draw_flip;
          st_frame[n_starts] = draw_frame;
          st_row[n_starts]   = draw_row;
        end
        n_starts++;
        c_col = draw_col; c_flip = draw_flip; c_frame = draw_frame; c_row = draw_row;
        hold = 1'b1;
        cs   = 0;
      end
      if (line_done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({attr_addr, draw_start, draw_col, draw_flip, draw_frame, draw_row, busy, line_done,
         hit_count, overflow, overrun} !== 43'd0) begin
      failures++;
      $display("FAIL reset_outputs: got addr=%0d start=%b col=%0d flip=%b frame=%0h row=%0d busy=%b done=%b hc=%0d ovf=%b ovr=%b required all 0",
               attr_addr, draw_start, draw_col, draw_flip, draw_frame, draw_row, busy,
               line_done, hit_count, overflow, overrun);
    end
  endtask

  task automatic test_empty();
    int dk;
    clear_sat();
    run_scan(10'd100, 300, dk);
    checks++; if (dk !== 129) begin failures++; $display("FAIL empty_done_cycle: got %0d required 129", dk); end
    checks++; if (n_starts !== 0) begin failures++; $display("FAIL empty_starts: got %0d required 0", n_starts); end
    checks++; if (busy1 !== 1'b1) begin failures++; $display("FAIL empty_busy_t1: got %b required 1", busy1); end
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL empty_no_overrun: got %b required 0", ov0); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL empty_busy_at_done: got %b required 1", busy); end
    checks++; if (hit_count !== 5'd0) begin failures++; $display("FAIL empty_hit_count: got %0d required 0", hit_count); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy_after: got %b required 0", busy); end
  endtask

  task automatic test_single_hit();
    int dk;
    clear_sat();
    sat[5] = ent(1'b1, 1'b1, 10'd200, 10'd90, 8'h12);
    run_scan(10'd100, 400, dk);
    checks++; if (dk !== 148) begin failures++; $display("FAIL hit_done_cycle: got %0d required 148", dk); end
    checks++; if (n_starts !== 1) begin failures++; $display("FAIL hit_starts: got %0d required 1", n_starts); end
    checks++; if (st_k[0] !== 13) begin failures++; $display("FAIL hit_start_cycle: got %0d required 13", st_k[0]); end
    checks++;
    if ({st_col[0], st_flip[0], st_frame[0], st_row[0]} !== {10'd200, 1'b1, 8'h12, 4'd10}) begin
      failures++;
      $display("FAIL hit_fields: got col=%0d flip=%b frame=%0h row=%0d required col=200 flip=1 frame=12 row=10",
               st_col[0], st_flip[0], st_frame[0], st_row[0]);
    end
    checks++; if (stab_err !== 0) begin failures++; $display("FAIL hit_fields_stable: got %0d changes required 0", stab_err); end
    checks++; if (hit_count !== 5'd1) begin failures++; $display("FAIL hit_count_one: got %0d required 1", hit_count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL hit_no_overflow: got %b required 0", overflow); end
  endtask

  task automatic test_wrap();
    int dk;
    clear_sat();
    sat[0] = ent(1'b1, 1'b0, 10'd7, 10'd1020, 8'h03);
    run_scan(10'd3, 400, dk);
    checks++; if (n_starts !== 1 || st_row[0] !== 4'd7 || st_k[0] !== 3) begin
      failures++; $display("FAIL wrap_line3: got starts=%0d row=%0d cycle=%0d required 1/7/3", n_starts, st_row[0], st_k[0]); end
    checks++; if (st_col[0] !== 10'd7) begin failures++; $display("FAIL wrap_col: got %0d required 7", st_col[0]); end
    checks++; if (dk !== 148) begin failures++; $display("FAIL wrap_done_cycle: got %0d required 148", dk); end
    run_scan(10'd12, 400, dk);
    checks++; if (n_starts !== 0 || dk !== 129) begin
      failures++; $display("FAIL wrap_line12: got starts=%0d done=%0d required 0/129", n_starts, dk); end
    run_scan(10'd1023, 400, dk);
    checks++; if (n_starts !== 1 || st_row[0] !== 4'd3) begin
      failures++; $display("FAIL wrap_line1023: got starts=%0d row=%0d required 1/3", n_starts, st_row[0]); end
  endtask

  task automatic test_overflow();
    int dk;
    clear_sat();
    for (int i = 0; i < 20; i++) sat[i] = ent(1'b1, 1'b0, 10'(i * 8), 10'd495, 8'(i));
    run_scan(10'd500, 1000, dk);
    checks++; if (n_starts !== 16) begin failures++; $display("FAIL ovf_starts: got %0d required 16", n_starts); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (st_frame[i] !== 8'(i) || st_row[i] !== 4'd5) begin
        failures++;
        $display("FAIL ovf_order_%0d: got frame=%0d row=%0d required frame=%0d row=5", i, st_frame[i], st_row[i], i);
      end
    end
    checks++; if (hit_count !== 5'd16) begin failures++; $display("FAIL ovf_hit_count: got %0d required 16", hit_count); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    checks++; if (dk !== 433) begin failures++; $display("FAIL ovf_done_cycle: got %0d required 433", dk); end
    clear_sat();
    run_scan(10'd500, 300, dk);
    checks++; if (overflow !== 1'b0 || hit_count !== 5'd0) begin
      failures++; $display("FAIL ovf_cleared: got ovf=%b hc=%0d required 0/0", overflow, hit_count); end
  endtask

  task automatic test_overrun();
    int dk;
    int got;
    int ld_seen;
    clear_sat();
    sat[5] = ent(1'b1, 1'b0, 10'd50, 10'd90, 8'h44);
    got = 0;
    ld_seen = 0;
    @(posedge clk); #1;
    line_start = 1'b1;
    line_y     = 10'd100;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (draw_start) got = k;
      if (line_done) ld_seen++;
      if (got > 0 && k == got + 5) break;
    end
    checks++; if (got !== 13) begin failures++; $display("FAIL ovr_first_start: got %0d required 13", got); end
    run_scan(10'd95, 400, dk);
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL ovr_pulse: got %b required 1", ov0); end
    checks++; if (ld_seen !== 0 || ld0 !== 1'b0) begin
      failures++; $display("FAIL ovr_aborted_done: got %0d/%b required 0/0", ld_seen, ld0); end
    checks++; if (n_starts !== 1 || st_k[0] !== 13 || st_row[0] !== 4'd5) begin
      failures++; $display("FAIL ovr_restart: got starts=%0d cycle=%0d row=%0d required 1/13/5", n_starts, st_k[0], st_row[0]); end
    checks++; if (dk !== 148) begin failures++; $display("FAIL ovr_done_cycle: got %0d required 148", dk); end
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_idle_low: got %b required 0", overrun); end
  endtask

  task automatic test_finish_collision();
    int dk;
    int ld_seen;
    clear_sat();
    ld_seen = 0;
    @(posedge clk); #1;
    line_start = 1'b1;
    line_y     = 10'd300;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int k = 1; k <= 128; k++) begin
      @(negedge clk);
      if (line_done) ld_seen++;
    end
    run_scan(10'd301, 300, dk);
    checks++; if (ld_seen !== 0 || ld0 !== 1'b0) begin
      failures++; $display("FAIL fin_done_suppressed: got early=%0d at_finish=%b required 0/0", ld_seen, ld0); end
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL fin_overrun: got %b required 1", ov0); end
    checks++; if (dk !== 129) begin failures++; $display("FAIL fin_restart_done: got %0d required 129", dk); end
  endtask

  task automatic test_slow_drawer();
    int dk;
    clear_sat();
    sat[5] = ent(1'b1, 1'b1, 10'd200, 10'd90, 8'h12);
    slow = 1'b1;
    run_scan(10'd100, 400, dk);
    slow = 1'b0;
    checks++; if (dk !== 148) begin failures++; $display("FAIL slow_done_cycle: got %0d required 148", dk); end
    checks++; if (n_starts !== 1 || stab_err !== 0) begin
      failures++; $display("FAIL slow_handshake: got starts=%0d changes=%0d required 1/0", n_starts, stab_err); end
  endtask

  task automatic test_reset_mid_wait();
    int got;
    int extra_st;
    int extra_ld;
    clear_sat();
    sat[5] = ent(1'b1, 1'b0, 10'd9, 10'd90, 8'h21);
    got = 0;
    extra_st = 0;
    extra_ld = 0;
    @(posedge clk); #1;
    line_start = 1'b1;
    line_y     = 10'd100;
    @(posedge clk); #1;
    line_start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (draw_start) got = k;
      if (got > 0 && k == got + 4) break;
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || hit_count !== 5'd0 || draw_col !== 10'd0) begin
      failures++; $display("FAIL rst_wait_state: got busy=%b hc=%0d col=%0d required 0/0/0", busy, hit_count, draw_col); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (draw_start) extra_st++;
      if (line_done)  extra_ld++;
    end
    checks++; if (extra_st !== 0 || extra_ld !== 0) begin
      failures++; $display("FAIL rst_wait_quiet: got starts=%0d dones=%0d required 0/0", extra_st, extra_ld); end
  endtask

  initial begin
    clear_sat();
    test_reset();
    test_empty();
    test_single_hit();
    test_wrap();
    test_overflow();
    test_overrun();
    test_finish_collision();
    test_slow_drawer();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
